// File: rtl/imm_ext_pipe.sv
// Immediate extender (zero/sign/upper/shifted-offset) feeding a registered 2-entry
// valid/ready output buffer; outputs come straight from the head register.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
    logic signed [OUT_W-1:0] sx;
    sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    unique case (mode)
      2'b00:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b01:   extend = sx;
      2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
      default: extend = sx <<< SHIFT;
    endcase
  endfunction

  logic [1:0]       count;
  logic             vld_p1;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] ext_p0;
  logic             neg_p0;
  logic [OUT_W-1:0] head_data_p1;
  logic             head_neg_p1;
  logic [OUT_W-1:0] tail_data_p1;
  logic             tail_neg_p1;

  // p0: combinational extension of the incoming immediate
  assign ext_p0 = extend(in_imm, in_mode);
  assign neg_p0 = in_imm[IN_W-1];

  assign in_ready  = (count != 2'd2) & ~reset;
  assign vld_p1    = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = vld_p1 & out_ready;
  assign out_valid = vld_p1;
  assign out_data  = head_data_p1;
  assign out_neg   = head_neg_p1;

  // p1: head register is the presented entry; it is cleared on reset so out_data reads 0
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= 2'd0;
      head_data_p1 <= '0;
      head_neg_p1  <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data_p1 <= ext_p0;
            head_neg_p1  <= neg_p0;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_data_p1 <= tail_data_p1;
            head_neg_p1  <= tail_neg_p1;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          // only reachable at count==1: the new entry replaces the popped head
          head_data_p1 <= ext_p0;
          head_neg_p1  <= neg_p0;
        end
        default: ;
      endcase
    end
  end

  // Second slot only holds data while the head is occupied and not leaving
  always_ff @(posedge clk) begin
    if (push && !pop && count == 2'd1) begin
      tail_data_p1 <= ext_p0;
      tail_neg_p1  <= neg_p0;
    end
  end

endmodule
